// File: rtl/fetch_unit.sv
// fetch_unit
//   Instruction fetch stage. It holds the fetch PC, a 2-entry queue of
//   {pc, instr} pairs feeding decode, and a RUN/HALTED state machine.
//   Fetching stops after a HALT_OPCODE instruction is enqueued. A redirect
//   flushes the queue, reloads the PC and restarts fetching.
//
// Parameters
//   RESET_PC         byte address loaded into the PC on reset
//   HALT_OPCODE      instr[15:12] value that stops fetching
//
// Ports
//   clk              rising-edge clock
//   reset_n          asynchronous active-low reset
//   imem_addr        fetch byte address (the PC register itself)
//   imem_data        instruction at imem_addr, valid in the same cycle
//   redirect         taken branch/jump: flush and restart fetch
//   redirect_target  new fetch address, sampled while redirect=1
//   if_valid         head queue entry presented to decode
//   if_ready         decode accepts the head entry this cycle
//   if_instr         head entry instruction
//   if_pc            head entry byte address
//   halted           state machine is in HALTED

module fetch_unit #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect,
  input  logic [15:0] redirect_target,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [15:0] if_pc,
  output logic        halted
);

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  state_t      state;
  logic [15:0] pc;
  logic [1:0]  count;

  // Slot 0 is always the head; slot 1 only ever holds the second entry.
  logic [15:0] q_pc    [2];
  logic [15:0] q_instr [2];

  logic        deq;
  logic        fetch;
  logic        tail_is_1;
  logic        is_halt;

  assign imem_addr = pc;
  assign if_valid  = (count != 2'd0) && !redirect;
  assign if_pc     = q_pc[0];
  assign if_instr  = q_instr[0];
  assign halted    = (state == ST_HALTED);

  assign deq     = if_valid && if_ready;
  assign fetch   = (state == ST_RUN) && !redirect &&
                   ((count != 2'd2) || deq);
  assign is_halt = (imem_data[15:12] == HALT_OPCODE);

  // The write slot is the occupancy left after this cycle's dequeue:
  // slot 1 when one entry survives, otherwise slot 0.
  assign tail_is_1 = ((count == 2'd2) && deq) || ((count == 2'd1) && !deq);

  // Slot 0 is only overwritten by a shift or a new entry, so when the queue
  // drains or is flushed the last head stays visible on if_pc/if_instr.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_RUN;
      pc         <= RESET_PC;
      count      <= 2'd0;
      q_pc[0]    <= 16'h0000;
      q_pc[1]    <= 16'h0000;
      q_instr[0] <= 16'h0000;
      q_instr[1] <= 16'h0000;
    end else if (redirect) begin
      state <= ST_RUN;
      pc    <= {redirect_target[15:1], 1'b0};
      count <= 2'd0;
    end else begin
      if (deq && (count == 2'd2)) begin
        q_pc[0]    <= q_pc[1];
        q_instr[0] <= q_instr[1];
      end
      if (fetch) begin
        if (tail_is_1) begin
          q_pc[1]    <= pc;
          q_instr[1] <= imem_data;
        end else begin
          q_pc[0]    <= pc;
          q_instr[0] <= imem_data;
        end
        pc <= pc + 16'd2;
        if (is_halt) begin
          state <= ST_HALTED;
        end
      end
      count <= count + {1'b0, fetch} - {1'b0, deq};
    end
  end

endmodule
